// File: rtl/contador_modulo_if.sv
// Control and status bundle for one modulo counter stage: tick/direction/preset in,
// binary count, BCD digits, wrap pulses and look-ahead limit flag out.
interface contador_modulo_if #(
   parameter int WIDTH = 6
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic [3:0]       units;
   logic [3:0]       tens;
   logic             carry;
   logic             borrow;
   logic             at_limit;

   modport master (
      output en, up, load, load_value,
      input  count, units, tens, carry, borrow, at_limit
   );

   modport slave (
      input  en, up, load, load_value,
      output count, units, tens, carry, borrow, at_limit
   );
endinterface

// File: rtl/contador_modulo.sv
// Modulo-N up/down counter with preset, carry/borrow wrap pulses and registered BCD digits.
// One-cycle latency from en/load to count; no backpressure, a tick is consumed every edge it is high.
module contador_modulo #(
   parameter int MODULO = 60,
   parameter int WIDTH  = 6
) (
   input  logic                clock,
   input  logic                reset_n,
   contador_modulo_if.slave    bus
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] count_q, count_nxt;
   logic [3:0]       units_q, tens_q;
   logic             carry_q, borrow_q;
   logic             carry_nxt, borrow_nxt;
   logic [7:0]       bcd_nxt;

   // Repeated subtraction with a fixed trip count keeps the digit split shallow and divider-free.
   function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
      logic [6:0] rem;
      logic [3:0] t;
      rem = 7'(v);
      t   = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 7'd10) begin
            rem = rem - 7'd10;
            t   = t + 4'd1;
         end
      end
      return {t, rem[3:0]};
   endfunction

   always_comb begin
      count_nxt  = count_q;
      carry_nxt  = 1'b0;
      borrow_nxt = 1'b0;
      if (bus.load) begin
         count_nxt = (bus.load_value > LAST) ? LAST : bus.load_value;
      end else if (bus.en) begin
         if (bus.up) begin
            if (count_q == LAST) begin
               count_nxt = '0;
               carry_nxt = 1'b1;
            end else begin
               count_nxt = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_nxt  = LAST;
               borrow_nxt = 1'b1;
            end else begin
               count_nxt = count_q - WIDTH'(1);
            end
         end
      end
      bcd_nxt = to_bcd(count_nxt);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         units_q  <= 4'd0;
         tens_q   <= 4'd0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_nxt;
         units_q  <= bcd_nxt[3:0];
         tens_q   <= bcd_nxt[7:4];
         carry_q  <= carry_nxt;
         borrow_q <= borrow_nxt;
      end
   end

   assign bus.count    = count_q;
   assign bus.units    = units_q;
   assign bus.tens     = tens_q;
   assign bus.carry    = carry_q;
   assign bus.borrow   = borrow_q;
   // Look-ahead only: tells the next stage this edge would wrap if enabled.
   assign bus.at_limit = bus.up ? (count_q == LAST) : (count_q == '0);
endmodule

// File: tb/tb_contador_modulo.sv
// Directed bench: one MODULO=60 counter plus a seconds/minutes/hours cascade.
module tb_contador_modulo;
   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   contador_modulo_if #(.WIDTH(6)) d_if ();
   contador_modulo_if #(.WIDTH(6)) s_if ();
   contador_modulo_if #(.WIDTH(6)) m_if ();
   contador_modulo_if #(.WIDTH(5)) h_if ();

   contador_modulo #(.MODULO(60), .WIDTH(6)) u_dut (.clock(clock), .reset_n(reset_n), .bus(d_if));
   contador_modulo #(.MODULO(60), .WIDTH(6)) u_sec (.clock(clock), .reset_n(reset_n), .bus(s_if));
   contador_modulo #(.MODULO(60), .WIDTH(6)) u_min (.clock(clock), .reset_n(reset_n), .bus(m_if));
   contador_modulo #(.MODULO(24), .WIDTH(5)) u_hr  (.clock(clock), .reset_n(reset_n), .bus(h_if));

   assign m_if.en = s_if.carry | s_if.borrow;
   assign m_if.up = s_if.up;
   assign h_if.en = m_if.carry | m_if.borrow;
   assign h_if.up = m_if.up;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_dut(input string tag, input int c, input int cy, input int bw);
      chk({tag, ".count"},  32'(d_if.count),  32'(c));
      chk({tag, ".units"},  32'(d_if.units),  32'(c % 10));
      chk({tag, ".tens"},   32'(d_if.tens),   32'(c / 10));
      chk({tag, ".carry"},  32'(d_if.carry),  32'(cy));
      chk({tag, ".borrow"}, 32'(d_if.borrow), 32'(bw));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      d_if.en = 1'b0; d_if.up = 1'b0; d_if.load = 1'b0; d_if.load_value = '0;
      s_if.en = 1'b0; s_if.up = 1'b1; s_if.load = 1'b0; s_if.load_value = '0;
      m_if.load = 1'b0; m_if.load_value = '0;
      h_if.load = 1'b0; h_if.load_value = '0;

      // Reset state
      #12;
      chk_dut("reset", 0, 0, 0);
      chk("reset.at_limit_down", 32'(d_if.at_limit), 32'd1);
      d_if.en = 1'b1;
      d_if.up = 1'b1;
      #1 reset_n = 1'b1;

      // Continuous up count through one full wrap
      for (int i = 1; i <= 61; i++) begin
         step();
         chk_dut($sformatf("up%0d", i), i % 60, (i == 60) ? 1 : 0, 0);
         if (i == 59) chk("up59.at_limit", 32'(d_if.at_limit), 32'd1);
      end

      // Load 0 then count down: borrow wrap
      d_if.en = 1'b0; d_if.load = 1'b1; d_if.load_value = 6'd0;
      step();
      chk_dut("load0", 0, 0, 0);
      d_if.load = 1'b0; d_if.en = 1'b1; d_if.up = 1'b0;
      step();
      chk_dut("down_wrap", 59, 0, 1);
      step();
      chk_dut("down_next", 58, 0, 0);

      // Load beats enable; clamp of out-of-range preset
      d_if.up = 1'b1; d_if.load = 1'b1; d_if.load_value = 6'd45;
      step();
      chk_dut("load45", 45, 0, 0);
      d_if.load_value = 6'd63;
      step();
      chk_dut("load63_clamp", 59, 0, 0);
      chk("clamp.at_limit_up", 32'(d_if.at_limit), 32'd1);

      // Hold at the limit, then resume
      d_if.load = 1'b0; d_if.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_dut($sformatf("hold%0d", i), 59, 0, 0);
      end
      d_if.en = 1'b1;
      step();
      chk_dut("resume_wrap", 0, 1, 0);
      step();
      chk_dut("resume_next", 1, 0, 0);

      // Cascade preset 23:59:59 (hours via clamped 30), one tick
      s_if.load = 1'b1; s_if.load_value = 6'd59;
      m_if.load = 1'b1; m_if.load_value = 6'd59;
      h_if.load = 1'b1; h_if.load_value = 5'd30;
      step();
      chk("casc.preset_sec", 32'(s_if.count), 32'd59);
      chk("casc.preset_min", 32'(m_if.count), 32'd59);
      chk("casc.preset_hr_clamp", 32'(h_if.count), 32'd23);
      s_if.load = 1'b0; m_if.load = 1'b0; h_if.load = 1'b0;
      s_if.en = 1'b1;
      step();
      s_if.en = 1'b0;
      chk("casc.t1_sec", 32'(s_if.count), 32'd0);
      chk("casc.t1_sec_carry", 32'(s_if.carry), 32'd1);
      chk("casc.t1_min", 32'(m_if.count), 32'd59);
      step();
      chk("casc.t2_min", 32'(m_if.count), 32'd0);
      chk("casc.t2_min_carry", 32'(m_if.carry), 32'd1);
      chk("casc.t2_hr", 32'(h_if.count), 32'd23);
      chk("casc.t2_sec_carry", 32'(s_if.carry), 32'd0);
      step();
      chk("casc.t3_hr", 32'(h_if.count), 32'd0);
      chk("casc.t3_hr_carry", 32'(h_if.carry), 32'd1);
      chk("casc.t3_hr_tens", 32'(h_if.tens), 32'd0);
      step();
      chk("casc.t4_hr_carry", 32'(h_if.carry), 32'd0);
      chk("casc.t4_min", 32'(m_if.count), 32'd0);

      // Asynchronous reset just after reaching 59, before the wrap edge
      d_if.en = 1'b0; d_if.load = 1'b1; d_if.load_value = 6'd58;
      step();
      d_if.load = 1'b0; d_if.en = 1'b1; d_if.up = 1'b1;
      step();
      chk_dut("pre_reset", 59, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      chk_dut("async_reset", 0, 0, 0);
      step();
      chk_dut("in_reset", 0, 0, 0);
      #3 reset_n = 1'b1;
      step();
      chk_dut("post_reset", 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/contador_modulo.md
Name: contador_modulo

Overview:
- Parametrised modulo-N up/down time counter for the digital-clock datapath. It generalises the fixed 0..59 seconds counter.
- Adds tick enable, direction control, synchronous preset (time setting), separate carry and borrow pulses for cascading, and registered BCD digits for the display driver.
- One instance per field: seconds and minutes use MODULO=60, hours use MODULO=24. Stages chain through their carry/borrow outputs.

Parameters:
- MODULO, 60, count range 0..MODULO-1. Legal range 2..100.
- WIDTH, 6, binary count width. Must satisfy 2^WIDTH >= MODULO.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  count enable (tick); one step per rising edge while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous preset strobe
- load_value  input  WIDTH  preset value
- count  output  WIDTH  registered binary count
- units  output  4  registered BCD units digit of count
- tens  output  4  registered BCD tens digit of count
- carry  output  1  registered one-cycle pulse on up-wrap
- borrow  output  1  registered one-cycle pulse on down-wrap
- at_limit  output  1  combinational: count==MODULO-1 when up=1, count==0 when up=0

Behaviour:
- Reset (reset_n low, asynchronous, any cycle): count=0, units=0, tens=0, carry=0, borrow=0. Release takes effect on the next rising edge. Reset mid-count discards all state; no pending pulse survives.
- Priority at each rising edge: load > en > hold.
- Load:
  - count <= load_value if load_value < MODULO, else count <= MODULO-1 (clamped).
  - carry and borrow are driven 0 that cycle; en is ignored that cycle.
- Enable, up=1:
  - If count < MODULO-1: count <= count+1, carry <= 0.
  - If count == MODULO-1: count <= 0, carry <= 1.
- Enable, up=0:
  - If count > 0: count <= count-1, borrow <= 0.
  - If count == 0: count <= MODULO-1, borrow <= 1.
- Hold (en=0, load=0): count unchanged; carry <= 0, borrow <= 0.
- Pulse width and timing:
  - carry and borrow are high for exactly one cycle, the cycle in which count shows the wrapped value. They are never high together.
  - Cascading: the next stage's en is tied to this stage's carry|borrow and its up to the same up. The next stage therefore steps one clock after the wrap edge, a fixed one-cycle skew per stage.
- Continuous enable: with en held high, count steps every cycle. At a wrap, carry is high for one cycle and then low, even though en stays high.
- BCD:
  - units and tens are updated on the same edge as count, from the next-state value.
  - Invariant at all times: units == count mod 10 and tens == count / 10.
  - For MODULO <= 10, tens is always 0.
  - No arithmetic divider in the clocked path beyond a constant-bound conversion of the next-state value.
- Direction change: takes effect on the first edge where up is sampled at its new value. No extra cycle, no glitch pulse.
- Arithmetic: count never takes a value >= MODULO under any input sequence.
- at_limit is purely combinational from count and up. It is for look-ahead only and is not registered.

Test Plan:
- Reset, then en=1, up=1 for 61 cycles (MODULO=60) -> count 1..59, then 0 with carry=1 for exactly one cycle; tens/units = 5/9 just before the wrap; count=1, carry=0 on the following cycle.
- load=1, load_value=0; then en=1, up=0 -> count=59, borrow=1 for one cycle, units=9, tens=5; next edge count=58, borrow=0.
- load_value=45 with en=1 in the same cycle -> count=45 (load wins), carry=0; load_value=63 -> count=59 (clamp); MODULO=24 instance, load_value=30 -> count=23.
- Count at 59, up=1, then en dropped for 5 cycles -> count holds at 59, carry stays 0; re-enable -> wrap to 0 with carry pulse.
- Cascade of seconds (60), minutes (60) and hours (24) stages, preset to 23:59:59, one tick -> 00:00:00, with minutes and hours updating 1 and 2 cycles after the seconds wrap respectively.
- reset_n asserted asynchronously mid-cycle, just after count reaches 59 (before the wrap edge) -> all outputs 0 immediately; no carry after release.
